ula_fsm_param: RTL and testbench

ULA_FSM_PARAM -- requirements
Module: ula_fsm_param

---
 rtl/ula_pkg.sv | 25 ++
 rtl/botao_debounce.sv | 56 +++++
 rtl/ula_fsm_param.sv | 204 ++++++++++++++++++++
 tb/tb_ula_fsm_param.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared state and opcode encodings for the ULA calculator FSM.
// Pure declarations; no logic, no latency.
package ula_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_LOAD_OP = 3'd3,
    ST_CALC    = 3'd4,
    ST_SHOW    = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_NOT = 3'b111
  } op_t;

endpackage

// File: rtl/botao_debounce.sv
// Active-low button synchroniser + debouncer emitting one pulse per accepted press.
// Latency: 2 sync flops + DEBOUNCE_CYCLES stable cycles; no backpressure, pulse is fire-and-forget.
module botao_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CNTW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            stable_q, stable_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    sync1_d  = key_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    // Any sample matching the accepted level restarts the stability count.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        pulse_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign press_pulse = pulse_q;

endmodule

// File: rtl/ula_fsm_param.sv
// Button-stepped ALU: load A, B, opcode, compute (1 cycle, or WIDTH cycles for mul/div), show.
// Latency: CALC is 1 or WIDTH cycles; presses arriving during CALC are dropped, not queued.
module ula_fsm_param
  import ula_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DISPLAY     = 99
) (
  input  logic               CLOCK_50,
  input  logic               RESET_N,
  input  logic [WIDTH-1:0]   SW,
  input  logic               KEY_NEXT,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic [WIDTH-1:0]   reg_a,
  output logic [WIDTH-1:0]   reg_b,
  output logic               flag_zero,
  output logic               flag_neg,
  output logic               flag_over,
  output logic               flag_div0,
  output logic [2:0]         state,
  output logic               busy,
  output logic               done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int unsigned MAX_U = MAX_DISPLAY;

  logic press;

  botao_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk        (CLOCK_50),
    .rst_n      (RESET_N),
    .key_n      (KEY_NEXT),
    .press_pulse(press)
  );

  state_t             state_q, state_d;
  op_t                op_q, op_d;
  logic [WIDTH-1:0]   reg_a_q, reg_a_d, reg_b_q, reg_b_d;
  logic [2*WIDTH-1:0] result_q, result_d, acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d, part_q, part_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic zero_q, zero_d, neg_q, neg_d, over_q, over_d, div0_q, div0_d, done_q, done_d;

  logic [2*WIDTH-1:0] a_ext, b_ext, alu_res, mul_nxt, fin_res;
  logic [WIDTH:0]     rs, diff;
  logic               q_bit, fin, fin_neg, fin_div0;
  logic [WIDTH-1:0]   part_nxt, quo_nxt, fin_rem;

  always_comb begin
    a_ext    = {{WIDTH{1'b0}}, reg_a_q};
    b_ext    = {{WIDTH{1'b0}}, reg_b_q};
    // Multiplier and divider share cnt_q; acc_q is the product or the quotient.
    mul_nxt  = acc_q + (reg_b_q[cnt_q] ? (a_ext << cnt_q) : '0);
    rs       = {part_q, reg_a_q[LAST - cnt_q]};
    diff     = rs - {1'b0, reg_b_q};
    q_bit    = (rs >= {1'b0, reg_b_q});
    part_nxt = q_bit ? diff[WIDTH-1:0] : rs[WIDTH-1:0];
    quo_nxt  = {acc_q[WIDTH-2:0], q_bit};

    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = (reg_b_q > reg_a_q) ? (b_ext - a_ext) : (a_ext - b_ext);
      OP_AND:  alu_res = a_ext & b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~reg_a_q};
      default: alu_res = '0;
    endcase

    state_d  = state_q;
    op_d     = op_q;
    reg_a_d  = reg_a_q;
    reg_b_d  = reg_b_q;
    result_d = result_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    part_d   = part_q;
    cnt_d    = cnt_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    over_d   = over_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    fin      = 1'b0;
    fin_res  = alu_res;
    fin_rem  = '0;
    fin_neg  = 1'b0;
    fin_div0 = 1'b0;

    case (state_q)
      ST_IDLE:   if (press) state_d = ST_LOAD_A;
      ST_LOAD_A: if (press) begin reg_a_d = SW; state_d = ST_LOAD_B; end
      ST_LOAD_B: if (press) begin reg_b_d = SW; state_d = ST_LOAD_OP; end
      ST_LOAD_OP: if (press) begin
        op_d    = op_t'(SW[2:0]);
        cnt_d   = '0;
        acc_d   = '0;
        part_d  = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        case (op_q)
          OP_MUL: begin
            acc_d = mul_nxt;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin fin = 1'b1; fin_res = mul_nxt; end
          end
          OP_DIV: begin
            if (reg_b_q == '0) begin
              fin      = 1'b1;
              fin_res  = '0;
              fin_div0 = 1'b1;
            end else begin
              acc_d  = {{WIDTH{1'b0}}, quo_nxt};
              part_d = part_nxt;
              cnt_d  = cnt_q + 1'b1;
              if (cnt_q == LAST) begin
                fin     = 1'b1;
                fin_res = {{WIDTH{1'b0}}, quo_nxt};
                fin_rem = part_nxt;
              end
            end
          end
          OP_SUB: begin fin = 1'b1; fin_neg = (reg_b_q > reg_a_q); end
          default: fin = 1'b1;
        endcase
        if (fin) begin
          result_d = fin_res;
          rem_d    = fin_rem;
          zero_d   = (fin_res == '0);
          over_d   = fin_div0 || (32'(fin_res) > MAX_U);
          neg_d    = fin_neg;
          div0_d   = fin_div0;
          done_d   = 1'b1;
          state_d  = ST_SHOW;
        end
      end
      ST_SHOW: if (press) begin
        reg_a_d  = '0;
        reg_b_d  = '0;
        op_d     = OP_ADD;
        result_d = '0;
        rem_d    = '0;
        zero_d   = 1'b0;
        neg_d    = 1'b0;
        over_d   = 1'b0;
        div0_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      reg_a_q  <= '0;
      reg_b_q  <= '0;
      result_q <= '0;
      rem_q    <= '0;
      acc_q    <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      over_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      reg_a_q  <= reg_a_d;
      reg_b_q  <= reg_b_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      part_q   <= part_d;
      cnt_q    <= cnt_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      over_q   <= over_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
    end
  end

  assign result    = result_q;
  assign remainder = rem_q;
  assign reg_a     = reg_a_q;
  assign reg_b     = reg_b_q;
  assign flag_zero = zero_q;
  assign flag_neg  = neg_q;
  assign flag_over = over_q;
  assign flag_div0 = div0_q;
  assign state     = state_q;
  assign busy      = (state_q == ST_CALC);
  assign done      = done_q;

endmodule

// File: tb/tb_ula_fsm_param.sv
// Directed bench for ula_fsm_param with WIDTH=4, DEBOUNCE_CYCLES=4.
module tb_ula_fsm_param;

  localparam int W = 4;

  logic           CLOCK_50 = 1'b0;
  logic           RESET_N;
  logic [W-1:0]   SW;
  logic           KEY_NEXT;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder, reg_a, reg_b;
  logic           flag_zero, flag_neg, flag_over, flag_div0;
  logic [2:0]     state;
  logic           busy, done;

  ula_fsm_param #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .MAX_DISPLAY(99)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .SW       (SW),
    .KEY_NEXT (KEY_NEXT),
    .result   (result),
    .remainder(remainder),
    .reg_a    (reg_a),
    .reg_b    (reg_b),
    .flag_zero(flag_zero),
    .flag_neg (flag_neg),
    .flag_over(flag_over),
    .flag_div0(flag_div0),
    .state    (state),
    .busy     (busy),
    .done     (done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int passed = 0;
  int failed = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int trans_cnt = 0;
  logic [2:0] prev_state = 3'd0;

  always @(negedge CLOCK_50) begin
    if (busy === 1'b1) busy_cnt++;
    if (done === 1'b1) done_cnt++;
    if (state !== prev_state) trans_cnt++;
    prev_state = state;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press();
    @(negedge CLOCK_50) KEY_NEXT = 1'b0;
    repeat (10) @(negedge CLOCK_50);
    KEY_NEXT = 1'b1;
    repeat (10) @(negedge CLOCK_50);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] op, output int busy_d, output int done_d);
    int b0, d0;
    press();
    SW = a;
    press();
    SW = b;
    press();
    SW = {1'b0, op};
    b0 = busy_cnt;
    d0 = done_cnt;
    press();
    for (int i = 0; i < 40 && state !== 3'd5; i++) @(negedge CLOCK_50);
    check({tag, "_in_show"}, 32'(state), 32'd5);
    busy_d = busy_cnt - b0;
    done_d = done_cnt - d0;
  endtask

  int bd, dd, t0, d0;

  initial begin
    RESET_N  = 1'b0;
    KEY_NEXT = 1'b1;
    SW       = '0;
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    @(negedge CLOCK_50);
    check("rst_state", 32'(state), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({flag_zero, flag_neg, flag_over, flag_div0}), 32'd0);

    run_op("add", 4'd5, 4'd7, 3'b000, bd, dd);
    check("add_result", 32'(result), 32'd12);
    check("add_zero", 32'(flag_zero), 32'd0);
    check("add_over", 32'(flag_over), 32'd0);
    check("add_calc_cycles", 32'(bd), 32'd1);
    check("add_done_pulses", 32'(dd), 32'd1);
    check("add_reg_a", 32'(reg_a), 32'd5);
    check("add_reg_b", 32'(reg_b), 32'd7);
    press();
    check("clr1_state", 32'(state), 32'd0);
    check("clr1_result", 32'(result), 32'd0);
    check("clr1_regs", 32'({reg_a, reg_b}), 32'd0);

    run_op("sub", 4'd3, 4'd9, 3'b001, bd, dd);
    check("sub_result", 32'(result), 32'd6);
    check("sub_neg", 32'(flag_neg), 32'd1);
    press();

    run_op("mul", 4'd15, 4'd15, 3'b010, bd, dd);
    check("mul_calc_cycles", 32'(bd), 32'd4);
    check("mul_result", 32'(result), 32'd225);
    check("mul_over", 32'(flag_over), 32'd1);
    check("mul_done_pulses", 32'(dd), 32'd1);
    press();

    run_op("div", 4'd13, 4'd4, 3'b011, bd, dd);
    check("div_result", 32'(result), 32'd3);
    check("div_remainder", 32'(remainder), 32'd1);
    check("div_calc_cycles", 32'(bd), 32'd4);
    press();

    run_op("div0", 4'd13, 4'd0, 3'b011, bd, dd);
    check("div0_result", 32'(result), 32'd0);
    check("div0_flag", 32'(flag_div0), 32'd1);
    check("div0_over", 32'(flag_over), 32'd1);
    check("div0_calc_cycles", 32'(bd), 32'd1);
    press();
    check("clr2_state", 32'(state), 32'd0);
    check("clr2_result", 32'(result), 32'd0);
    check("clr2_remainder", 32'(remainder), 32'd0);
    check("clr2_flags", 32'({flag_zero, flag_neg, flag_over, flag_div0}), 32'd0);
    check("clr2_regs", 32'({reg_a, reg_b}), 32'd0);

    @(negedge CLOCK_50) KEY_NEXT = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    KEY_NEXT = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    check("glitch_state", 32'(state), 32'd0);

    t0 = trans_cnt;
    @(negedge CLOCK_50) KEY_NEXT = 1'b0;
    repeat (50) @(negedge CLOCK_50);
    KEY_NEXT = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("hold_transitions", 32'(trans_cnt - t0), 32'd1);
    check("hold_state", 32'(state), 32'd1);

    SW = 4'd15;
    press();
    SW = 4'd15;
    press();
    SW = 4'd2;
    @(negedge CLOCK_50) KEY_NEXT = 1'b0;
    for (int i = 0; i < 30 && busy !== 1'b1; i++) @(negedge CLOCK_50);
    check("rstmul_started", 32'(busy), 32'd1);
    d0 = done_cnt;
    @(negedge CLOCK_50);
    RESET_N  = 1'b0;
    KEY_NEXT = 1'b1;
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    check("rstmul_state", 32'(state), 32'd0);
    check("rstmul_result", 32'(result), 32'd0);
    check("rstmul_busy", 32'(busy), 32'd0);
    repeat (20) @(negedge CLOCK_50);
    check("rstmul_no_done", 32'(done_cnt - d0), 32'd0);
    check("rstmul_idle", 32'(state), 32'd0);
    check("rstmul_result_late", 32'(result), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
